led_mode_ctrl: RTL and testbench



---
 rtl/led_ctrl_pkg.sv | 47 ++++
 rtl/led_mode_ctrl_debounce.sv | 52 +++++
 rtl/led_mode_ctrl.sv | 147 ++++++++++++++
 tb/tb_led_mode_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED mode/speed controller.
package led_ctrl_pkg;

    localparam int LED_W = 8;
    localparam logic [1:0] SPEED_MAX = 2'd3;

    // Pattern end points that turn the bounce around.
    localparam logic [LED_W-1:0] LED_MSB = 8'h80;
    localparam logic [LED_W-1:0] LED_LSB = 8'h01;

    // Seed loaded into the pattern register on entering each mode.
    localparam logic [LED_W-1:0] SEED_ROT_R  = 8'h80;
    localparam logic [LED_W-1:0] SEED_ROT_L  = 8'h01;
    localparam logic [LED_W-1:0] SEED_BOUNCE = 8'h80;
    localparam logic [LED_W-1:0] SEED_BLINK  = 8'hFF;

    typedef enum logic [1:0] {
        ROT_R  = 2'd0,
        ROT_L  = 2'd1,
        BOUNCE = 2'd2,
        BLINK  = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            ROT_R:   return ROT_L;
            ROT_L:   return BOUNCE;
            BOUNCE:  return BLINK;
            default: return ROT_R;
        endcase
    endfunction

    function automatic logic [LED_W-1:0] seed_of(input mode_t m);
        case (m)
            ROT_R:   return SEED_ROT_R;
            ROT_L:   return SEED_ROT_L;
            BOUNCE:  return SEED_BOUNCE;
            default: return SEED_BLINK;
        endcase
    endfunction

endpackage

// File: rtl/led_mode_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a single
// registered pulse for every accepted 0->1 level change.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the raw button into the clk domain.
    // NOTE: clocked blocks use non-blocking assignments so sync2 takes sync1's pre-edge value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYC consecutive cycles; pulse on accepted rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                pulse <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED bank mode/speed controller: debounced buttons select one of four
// patterns and the step rate; a pause switch freezes the pattern.
// Optional build macro LED_DIM_EN adds a registered 25% duty gate on led.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 100000000,
    parameter int unsigned TICK_BASE    = 25000000,
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_mode,
    input  logic             btn_faster,
    input  logic             btn_slower,
    input  logic             pause,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode,
    output logic [1:0]       speed
);

    logic             mode_p;
    logic             fast_p;
    logic             slow_p;
    logic             pause_meta;
    logic             pause_s;

    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [LED_W-1:0] pat_q, pat_d;
    logic [1:0]       speed_q, speed_d;
    logic [31:0]      tick_q, tick_d;

    logic [31:0]      period_m1;
    logic             step;
    logic             speed_up;
    logic             speed_dn;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk(clk), .rst(rst), .raw(btn_mode), .pulse(mode_p)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_faster (
        .clk(clk), .rst(rst), .raw(btn_faster), .pulse(fast_p)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_slower (
        .clk(clk), .rst(rst), .raw(btn_slower), .pulse(slow_p)
    );

    // Pause is a level switch: synchronize only, no debounce.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_meta <= 1'b0;
            pause_s    <= 1'b0;
        end else begin
            pause_meta <= pause;
            pause_s    <= pause_meta;
        end
    end

    assign period_m1 = (TICK_BASE >> speed_q) - 32'd1;
    assign step      = !pause_s && (tick_q == period_m1);
    // Opposing pulses in the same cycle cancel; saturated presses do nothing.
    assign speed_up  = fast_p && !slow_p && (speed_q != SPEED_MAX);
    assign speed_dn  = slow_p && !fast_p && (speed_q != 2'd0);

    // Next-state logic: mode change wins over a step, speed change clears the timebase.
    // NOTE: every signal gets a default first so no branch can infer a latch.
    always_comb begin
        mode_d  = mode_q;
        dir_d   = dir_q;
        pat_d   = pat_q;
        speed_d = speed_q;
        tick_d  = tick_q;

        if (speed_up) begin
            speed_d = speed_q + 2'd1;
        end else if (speed_dn) begin
            speed_d = speed_q - 2'd1;
        end

        if (mode_p) begin
            mode_d = next_mode(mode_q);
            pat_d  = seed_of(mode_d);
            dir_d  = DIR_RIGHT;
            tick_d = '0;
        end else begin
            if (!pause_s) begin
                tick_d = step ? 32'd0 : tick_q + 32'd1;
                if (step) begin
                    case (mode_q)
                        ROT_R:  pat_d = {pat_q[0], pat_q[LED_W-1:1]};
                        ROT_L:  pat_d = {pat_q[LED_W-2:0], pat_q[LED_W-1]};
                        BOUNCE: begin
                            if (dir_q == DIR_RIGHT) begin
                                pat_d = pat_q >> 1;
                                if (pat_d == LED_LSB) dir_d = DIR_LEFT;
                            end else begin
                                pat_d = pat_q << 1;
                                if (pat_d == LED_MSB) dir_d = DIR_RIGHT;
                            end
                        end
                        default: pat_d = ~pat_q;
                    endcase
                end
            end
            if (speed_up || speed_dn) tick_d = '0;
        end
    end

    // State register for mode, pattern, direction, speed and timebase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= ROT_R;
            dir_q   <= DIR_RIGHT;
            pat_q   <= SEED_ROT_R;
            speed_q <= 2'd0;
            tick_q  <= '0;
        end else begin
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            pat_q   <= pat_d;
            speed_q <= speed_d;
            tick_q  <= tick_d;
        end
    end

    assign mode  = mode_q;
    assign speed = speed_q;

`ifdef LED_DIM_EN
    logic [1:0] dim_cnt;

    // Free-running duty counter gating a registered copy of the pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dim_cnt <= 2'd0;
            led     <= SEED_ROT_R;
        end else begin
            dim_cnt <= dim_cnt + 2'd1;
            led     <= pat_q & {LED_W{dim_cnt == 2'd0}};
        end
    end
`else
    assign led = pat_q;
`endif

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed bench for led_mode_ctrl with DEBOUNCE_CYC=4, TICK_BASE=16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_led_mode_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_faster = 1'b0;
    logic       btn_slower = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] led;
    logic [1:0] mode;
    logic [1:0] speed;

    int checks = 0;
    int errors = 0;

    led_mode_ctrl #(
        .CLK_HZ(100),
        .TICK_BASE(16),
        .DEBOUNCE_CYC(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_mode(btn_mode),
        .btn_faster(btn_faster),
        .btn_slower(btn_slower),
        .pause(pause),
        .led(led),
        .mode(mode),
        .speed(speed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise the selected buttons {slower, faster, mode}; the registered
    // effect of the press is visible 7 falling edges later.
    task automatic press_begin(input logic [2:0] sel);
        {btn_slower, btn_faster, btn_mode} = sel;
        wait_cyc(7);
    endtask

    task automatic press_end();
        {btn_slower, btn_faster, btn_mode} = 3'b000;
        wait_cyc(8);
    endtask

    logic [7:0] idle_seq [4]   = '{8'h80, 8'h40, 8'h20, 8'h10};
    logic [1:0] mode_seq [9]   = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [7:0] seed_seq [9]   = '{8'h80, 8'hFF, 8'h80, 8'h01, 8'h80, 8'hFF, 8'h80, 8'h01, 8'h80};
    logic [7:0] bounce_seq [16] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                                    8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};

    initial begin
        // Reset state
        wait_cyc(3);
        check("rst_led", led, 8'h80);
        check("rst_mode", mode, 2'd0);
        check("rst_speed", speed, 2'd0);
        rst = 1'b1;

        // Idle ROT_R stepping, exactly 16 cycles apart
        for (int i = 0; i < 3; i++) begin
            wait_cyc(15);
            check($sformatf("idle_hold%0d", i), led, idle_seq[i]);
            wait_cyc(1);
            check($sformatf("idle_step%0d", i), led, idle_seq[i+1]);
        end
        check("idle_mode", mode, 2'd0);
        check("idle_speed", speed, 2'd0);

        // Clean press: exact latency, seed 01, next step 02
        btn_mode = 1'b1;
        wait_cyc(6);
        check("press_early_mode", mode, 2'd0);
        check("press_early_led", led, 8'h10);
        wait_cyc(1);
        check("press_mode", mode, 2'd1);
        check("press_seed", led, 8'h01);
        wait_cyc(3);
        btn_mode = 1'b0;
        wait_cyc(12);
        check("rotl_hold", led, 8'h01);
        wait_cyc(1);
        check("rotl_step", led, 8'h02);
        check("rotl_mode", mode, 2'd1);

        // Three-cycle glitch is rejected
        btn_mode = 1'b1;
        wait_cyc(3);
        btn_mode = 1'b0;
        wait_cyc(12);
        check("glitch_mode", mode, 2'd1);

        // Cycle through modes (including a full lap from 0), ending in BOUNCE
        for (int i = 0; i < 9; i++) begin
            press_begin(3'b001);
            check($sformatf("cycle_mode%0d", i), mode, mode_seq[i]);
            check($sformatf("cycle_seed%0d", i), led, seed_seq[i]);
            press_end();
        end

        // BOUNCE sequence over 16 steps
        wait_cyc(7);
        check("bounce_hold", led, 8'h80);
        for (int i = 0; i < 16; i++) begin
            wait_cyc(i == 0 ? 1 : 16);
            check($sformatf("bounce%0d", i), led, bounce_seq[i]);
        end

        // Faster presses up to saturation
        for (int s = 1; s <= 3; s++) begin
            press_begin(3'b010);
            check($sformatf("faster%0d", s), speed, s[1:0]);
            press_end();
        end
        press_begin(3'b010);
        check("faster_sat", speed, 2'd3);
        press_end();

        // BLINK at speed 3: period 2
        press_begin(3'b001);
        check("blink_mode", mode, 2'd3);
        check("blink_seed", led, 8'hFF);
        wait_cyc(1);
        check("blink_t1", led, 8'hFF);
        wait_cyc(1);
        check("blink_t2", led, 8'h00);
        wait_cyc(1);
        check("blink_t3", led, 8'h00);
        wait_cyc(1);
        check("blink_t4", led, 8'hFF);
        press_end();

        // Opposing pulses cancel
        press_begin(3'b110);
        check("both_speed", speed, 2'd3);
        press_end();

        // Slower presses down to saturation
        for (int s = 2; s >= 0; s--) begin
            press_begin(3'b100);
            check($sformatf("slower%0d", s), speed, s[1:0]);
            press_end();
        end
        press_begin(3'b100);
        check("slower_sat", speed, 2'd0);
        press_end();

        // Pause during ROT_R: 40 held cycles delay the step from t=16 to t=56
        press_begin(3'b001);
        check("pause_mode", mode, 2'd0);
        check("pause_seed", led, 8'h80);
        press_end();
        pause = 1'b1;
        wait_cyc(12);
        check("pause_t20", led, 8'h80);
        wait_cyc(28);
        check("pause_t48", led, 8'h80);
        pause = 1'b0;
        wait_cyc(7);
        check("resume_hold", led, 8'h80);
        wait_cyc(1);
        check("resume_step", led, 8'h40);

        // Asynchronous reset mid-run
        press_begin(3'b010);
        check("pre_rst_speed", speed, 2'd1);
        press_end();
        press_begin(3'b001);
        check("pre_rst_mode", mode, 2'd1);
        press_end();
        #2;
        rst = 1'b0;
        #1;
        check("arst_led", led, 8'h80);
        check("arst_mode", mode, 2'd0);
        check("arst_speed", speed, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(15);
        check("post_rst_hold", led, 8'h80);
        wait_cyc(1);
        check("post_rst_step", led, 8'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
